control_multi: RTL and testbench
================================

Name: control_multi

Overview:
- Multi-cycle MIPS control unit: the successor to the single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and emits per-state control strobes.
- Sits between the instruction register (IR) and the datapath.
- New over the single-cycle unit:
  - parametrised multi-cycle MULTU wait
  - data-memory ready handshake
  - deterministic (no x) outputs
  - sticky illegal-opcode trap

Parameters:
MULT_CYCLES, 32, cycles MULTU occupies the multiplier (legal 1..2**CNT_W)
CNT_W, 8, width of the multiply wait counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr  in  32  IR contents; stable from DECODE until return to FETCH
mem_ready  in  1  data memory completes access this cycle
IRWrite  out  1  load IR
PCWrite  out  1  load PC (PC+4 in FETCH, jump target in DECODE)
RegDst  out  1  1=rt destination, 0=rd destination
RegWrite  out  1  register file write
ALUSrc  out  1  1=immediate
MemRead  out  1  data memory read
MemWrite  out  1  data memory write
MemtoReg  out  1  1=write-back from memory
Branch_EQ  out  1  conditional PC load if zero
Branch_NE  out  1  conditional PC load if not zero
Jump  out  1  select jump target
ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
mul_start  out  1  one-cycle multiplier start pulse
mul_busy  out  1  multiplier in progress
illegal  out  1  sticky unimplemented-opcode flag
state  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 MULW=5 ERR=6

Behaviour:
- Decoded opcodes: opcode=instr[31:26], funct=instr[5:0].
  - R-type=0
  - ADDIU=9, LW=35, SW=43, BEQ=4, BNE=5, J=2
  - Within R-type: MULTU funct 25; MFHI 16, MFLO 18, SLL 0 (ALUSrc=0).
  - NOP = instr==0.
- All outputs are combinational from state and instr. Every strobe not listed for a state is 0. Never drive x.
- Reset: rst high at a clock edge -> state=FETCH, counter=0, illegal=0. Reset aborts any state, including MULW and ERR.
- While rst is high, every output except state is forced to 0.
- FETCH: IRWrite=1, PCWrite=1. Next state DECODE.
- DECODE:
  - NOP -> FETCH.
  - J -> PCWrite=1, Jump=1, then FETCH.
  - MULTU -> mul_start=1, counter loaded with MULT_CYCLES-1, then MULW.
  - Other legal opcodes -> EXEC.
  - Unimplemented opcode or R funct -> ERR.
- EXEC:
  - R-type: ALUOp=10, ALUSrc=0. Next WB.
  - ADDIU: ALUOp=00, ALUSrc=1. Next WB.
  - LW/SW: ALUOp=00, ALUSrc=1. Next MEM.
  - BEQ: ALUOp=01, Branch_EQ=1. Next FETCH.
  - BNE: ALUOp=01, Branch_NE=1. Next FETCH.
- MEM:
  - LW: MemRead=1. SW: MemWrite=1.
  - Strobe is held and state is held while mem_ready=0.
  - On mem_ready=1: LW -> WB, SW -> FETCH.
- WB:
  - RegWrite=1.
  - R-type: RegDst=0, MemtoReg=0.
  - ADDIU: RegDst=1, MemtoReg=0.
  - LW: RegDst=1, MemtoReg=1.
  - Next FETCH.
- MULW:
  - mul_busy=1, all write strobes 0.
  - Counter decrements each cycle.
  - When counter==0, go to FETCH (exactly MULT_CYCLES cycles in MULW).
- ERR: illegal=1, all strobes 0. Held until rst.
- Latency in cycles, FETCH to next FETCH:
  - NOP 2, J 2, BEQ/BNE 3
  - R-type/ADDIU/SW 4 (SW with mem_ready=1 immediately)
  - LW 5 (+ stall cycles)
  - MULTU 2+MULT_CYCLES
- mem_ready is ignored outside MEM.
- MULT_CYCLES=1: MULW lasts one cycle.
- Counter is CNT_W bits wide; MULT_CYCLES-1 must fit.

Test Plan:
- ADDIU instr=0x24080005, mem_ready=1 -> states 0,1,2,4,0. In WB cycle: RegWrite=1, RegDst=1, MemtoReg=0. In EXEC: ALUSrc=1, ALUOp=00. RegWrite=1 in exactly one cycle.
- LW instr=0x8C090004, mem_ready low for 2 MEM cycles then high -> MEM lasts 3 cycles with MemRead=1 each cycle, then WB with MemtoReg=1. Total 7 cycles.
- MULTU instr=0x01090019, MULT_CYCLES=4 -> mul_start=1 for the DECODE cycle only, mul_busy=1 for exactly 4 cycles, next FETCH 6 cycles after the first FETCH, RegWrite=0 throughout.
- BNE instr=0x1509FFFE -> EXEC has Branch_NE=1, ALUOp=01, Branch_EQ=0. J instr=0x08000010 -> DECODE has PCWrite=1, Jump=1. Both return to FETCH.
- instr=0x3C010001 (opcode 15) -> ERR on the cycle after DECODE, illegal=1. Stays in ERR for 10 cycles with all strobes 0. rst clears to FETCH with illegal=0.
- rst asserted during MULW cycle 2 of 4 -> next state FETCH, mul_busy=0. No outputs asserted while rst is high.

Source files
------------

// File: rtl/control_multi.sv
// control_multi: multi-cycle MIPS control FSM with MULTU wait, memory handshake and sticky illegal trap
module control_multi #(
   parameter int MULT_CYCLES = 32,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        ALUSrc,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        Branch_EQ,
   output logic        Branch_NE,
   output logic        Jump,
   output logic [1:0]  ALUOp,
   output logic        mul_start,
   output logic        mul_busy,
   output logic        illegal,
   output logic [2:0]  state
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      MULW   = 3'd5,
      ERR    = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [5:0] op, fn;
   logic       is_nop, is_r, is_multu, is_ralu, is_addiu, is_lw, is_sw, is_beq, is_bne, is_j, is_exec;

   assign op       = instr[31:26];
   assign fn       = instr[5:0];
   assign is_nop   = (instr == 32'd0);
   assign is_r     = (op == 6'd0);
   assign is_multu = is_r & (fn == 6'd25);
   assign is_ralu  = is_r & ((fn == 6'd16) | (fn == 6'd18) | (fn == 6'd0));
   assign is_addiu = (op == 6'd9);
   assign is_lw    = (op == 6'd35);
   assign is_sw    = (op == 6'd43);
   assign is_beq   = (op == 6'd4);
   assign is_bne   = (op == 6'd5);
   assign is_j     = (op == 6'd2);
   assign is_exec  = is_ralu | is_addiu | is_lw | is_sw | is_beq | is_bne;

   // Next-state and multiply wait counter; counter is loaded so MULW lasts exactly MULT_CYCLES cycles
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            state_d = (is_nop | is_j) ? FETCH : is_multu ? MULW : is_exec ? EXEC : ERR;
            cnt_d   = is_multu ? CNT_W'(MULT_CYCLES - 1) : cnt_q;
         end
         EXEC:   state_d = (is_lw | is_sw) ? MEM : (is_r | is_addiu) ? WB : FETCH;
         MEM:    state_d = !mem_ready ? MEM : is_lw ? WB : FETCH;
         WB:     state_d = FETCH;
         MULW:   begin
            state_d = (cnt_q == '0) ? FETCH : MULW;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
         end
         ERR:    state_d = ERR;
         default: state_d = FETCH;
      endcase
   end

   // State and counter registers; reset aborts any state including MULW and ERR
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Per-state control strobes, all zero while reset is held
   always_comb begin
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegDst    = 1'b0;
      RegWrite  = 1'b0;
      ALUSrc    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      MemtoReg  = 1'b0;
      Branch_EQ = 1'b0;
      Branch_NE = 1'b0;
      Jump      = 1'b0;
      ALUOp     = 2'b00;
      mul_start = 1'b0;
      mul_busy  = 1'b0;
      illegal   = 1'b0;
      if (!rst) begin
         case (state_q)
            FETCH: begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
            end
            DECODE: begin
               PCWrite   = !is_nop & is_j;
               Jump      = !is_nop & is_j;
               mul_start = is_multu;
            end
            EXEC: begin
               ALUOp     = is_r ? 2'b10 : (is_beq | is_bne) ? 2'b01 : 2'b00;
               ALUSrc    = is_addiu | is_lw | is_sw;
               Branch_EQ = is_beq;
               Branch_NE = is_bne;
            end
            MEM: begin
               MemRead  = is_lw;
               MemWrite = is_sw;
            end
            WB: begin
               RegWrite = 1'b1;
               RegDst   = is_addiu | is_lw;
               MemtoReg = is_lw;
            end
            MULW:    mul_busy = 1'b1;
            ERR:     illegal  = 1'b1;
            default: ;
         endcase
      end
   end

   assign state = state_q;
endmodule

// File: tb/tb_control_multi.sv
// tb_control_multi: per-cycle directed vectors checking state and all control strobes
module tb_control_multi;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'd0;
   logic        mem_ready = 1'b0;
   logic        IRWrite, PCWrite, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg;
   logic        Branch_EQ, Branch_NE, Jump, mul_start, mul_busy, illegal;
   logic [1:0]  ALUOp;
   logic [2:0]  state;
   logic [15:0] ctrl;
   int          n_run = 0;
   int          n_fail = 0;

   localparam logic [15:0] C_IRW = 16'h8000, C_PCW = 16'h4000, C_RD  = 16'h2000, C_RW  = 16'h1000;
   localparam logic [15:0] C_AS  = 16'h0800, C_MR  = 16'h0400, C_MW  = 16'h0200, C_M2R = 16'h0100;
   localparam logic [15:0] C_BEQ = 16'h0080, C_BNE = 16'h0040, C_J   = 16'h0020, C_FUN = 16'h0010;
   localparam logic [15:0] C_SUB = 16'h0008, C_MS  = 16'h0004, C_MB  = 16'h0002, C_ILL = 16'h0001;
   localparam logic [15:0] C_F   = C_IRW | C_PCW;

   localparam logic [31:0] I_ADDIU = 32'h24080005, I_LW = 32'h8C090004, I_SW = 32'hAC090004;
   localparam logic [31:0] I_BNE = 32'h1509FFFE, I_BEQ = 32'h1109FFFE, I_J = 32'h08000010;
   localparam logic [31:0] I_MFLO = 32'h00004012, I_MULTU = 32'h01090019, I_LUI = 32'h3C010001;
   localparam logic [31:0] I_ADD = 32'h01095020;

   typedef struct {
      logic        r;
      logic [31:0] in;
      logic        mr;
      logic [2:0]  st;
      logic [15:0] c;
   } vec_t;

   vec_t vt[$];

   control_multi #(.MULT_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .Branch_EQ(Branch_EQ), .Branch_NE(Branch_NE), .Jump(Jump), .ALUOp(ALUOp),
      .mul_start(mul_start), .mul_busy(mul_busy), .illegal(illegal), .state(state)
   );

   assign ctrl = {IRWrite, PCWrite, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg,
                  Branch_EQ, Branch_NE, Jump, ALUOp, mul_start, mul_busy, illegal};

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic [31:0] in, input logic mr,
                       input logic [2:0] st, input logic [15:0] c, input string nm);
      @(negedge clk);
      rst       = r;
      instr     = in;
      mem_ready = mr;
      #1;
      n_run++;
      if (state !== st || ctrl !== c) begin
         n_fail++;
         $display("FAIL %s: state=%0d ctrl=%h, expected state=%0d ctrl=%h", nm, state, ctrl, st, c);
      end
   endtask

   initial begin
      vt.push_back('{1'b0, I_ADDIU, 1'b1, 3'd0, C_F});
      vt.push_back('{1'b0, I_ADDIU, 1'b1, 3'd1, 16'h0});
      vt.push_back('{1'b0, I_ADDIU, 1'b1, 3'd2, C_AS});
      vt.push_back('{1'b0, I_ADDIU, 1'b1, 3'd4, C_RW | C_RD});
      vt.push_back('{1'b0, I_LW, 1'b0, 3'd0, C_F});
      vt.push_back('{1'b0, I_LW, 1'b0, 3'd1, 16'h0});
      vt.push_back('{1'b0, I_LW, 1'b0, 3'd2, C_AS});
      vt.push_back('{1'b0, I_LW, 1'b0, 3'd3, C_MR});
      vt.push_back('{1'b0, I_LW, 1'b0, 3'd3, C_MR});
      vt.push_back('{1'b0, I_LW, 1'b1, 3'd3, C_MR});
      vt.push_back('{1'b0, I_LW, 1'b1, 3'd4, C_RW | C_RD | C_M2R});
      vt.push_back('{1'b0, I_SW, 1'b1, 3'd0, C_F});
      vt.push_back('{1'b0, I_SW, 1'b1, 3'd1, 16'h0});
      vt.push_back('{1'b0, I_SW, 1'b1, 3'd2, C_AS});
      vt.push_back('{1'b0, I_SW, 1'b1, 3'd3, C_MW});
      vt.push_back('{1'b0, I_BNE, 1'b1, 3'd0, C_F});
      vt.push_back('{1'b0, I_BNE, 1'b1, 3'd1, 16'h0});
      vt.push_back('{1'b0, I_BNE, 1'b1, 3'd2, C_BNE | C_SUB});
      vt.push_back('{1'b0, I_BEQ, 1'b0, 3'd0, C_F});
      vt.push_back('{1'b0, I_BEQ, 1'b0, 3'd1, 16'h0});
      vt.push_back('{1'b0, I_BEQ, 1'b0, 3'd2, C_BEQ | C_SUB});
      vt.push_back('{1'b0, I_J, 1'b1, 3'd0, C_F});
      vt.push_back('{1'b0, I_J, 1'b1, 3'd1, C_PCW | C_J});
      vt.push_back('{1'b0, 32'd0, 1'b1, 3'd0, C_F});
      vt.push_back('{1'b0, 32'd0, 1'b1, 3'd1, 16'h0});
      vt.push_back('{1'b0, I_MFLO, 1'b0, 3'd0, C_F});
      vt.push_back('{1'b0, I_MFLO, 1'b0, 3'd1, 16'h0});
      vt.push_back('{1'b0, I_MFLO, 1'b0, 3'd2, C_FUN});
      vt.push_back('{1'b0, I_MFLO, 1'b0, 3'd4, C_RW});
      vt.push_back('{1'b0, I_MULTU, 1'b0, 3'd0, C_F});
      vt.push_back('{1'b0, I_MULTU, 1'b0, 3'd1, C_MS});
      vt.push_back('{1'b0, I_MULTU, 1'b1, 3'd5, C_MB});
      vt.push_back('{1'b0, I_MULTU, 1'b0, 3'd5, C_MB});
      vt.push_back('{1'b0, I_MULTU, 1'b1, 3'd5, C_MB});
      vt.push_back('{1'b0, I_MULTU, 1'b0, 3'd5, C_MB});
      vt.push_back('{1'b0, I_MULTU, 1'b0, 3'd0, C_F});

      @(posedge clk);
      @(posedge clk);
      step(1'b1, 32'd0, 1'b0, 3'd0, 16'h0, "reset");
      foreach (vt[i])
         step(vt[i].r, vt[i].in, vt[i].mr, vt[i].st, vt[i].c, $sformatf("vec%0d", i));

      // reset in the second MULW cycle aborts the multiply
      step(1'b0, I_MULTU, 1'b0, 3'd1, C_MS, "mrst_dec");
      step(1'b0, I_MULTU, 1'b0, 3'd5, C_MB, "mrst_w1");
      step(1'b1, I_MULTU, 1'b1, 3'd5, 16'h0, "mrst_w2");
      step(1'b0, I_MULTU, 1'b0, 3'd0, C_F, "mrst_fetch");

      // unimplemented opcode traps and stays trapped until reset
      step(1'b0, I_LUI, 1'b0, 3'd1, 16'h0, "err_dec");
      for (int k = 0; k < 10; k++)
         step(1'b0, I_LUI, k[0], 3'd6, C_ILL, $sformatf("err_hold%0d", k));
      step(1'b1, I_LUI, 1'b0, 3'd6, 16'h0, "err_rst");
      step(1'b0, I_LUI, 1'b0, 3'd0, C_F, "err_clear");

      // unimplemented R-type funct also traps
      step(1'b0, I_ADD, 1'b0, 3'd1, 16'h0, "rerr_dec");
      step(1'b0, I_ADD, 1'b0, 3'd6, C_ILL, "rerr_trap");
      step(1'b1, I_ADD, 1'b0, 3'd6, 16'h0, "rerr_rst");
      step(1'b0, I_ADD, 1'b0, 3'd0, C_F, "rerr_clear");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
